// File: rtl/vga_sync_rx.sv
// VGA timing recovery: locks free-running h/v counters onto incoming
// hsync/vsync, reports lock state, recovered pixel position and a
// saturating count of timing errors seen while locked.
module vga_sync_rx #(
    parameter int HD = 640,
    parameter int HF = 16,
    parameter int HR = 96,
    parameter int HB = 48,
    parameter int VD = 480,
    parameter int VF = 10,
    parameter int VR = 2,
    parameter int VB = 33
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [2:0] rgb,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       video_on,
    output logic [2:0] rgb_cap,
    output logic       locked,
    output logic       frame_tick,
    output logic [7:0] err_cnt
);
    localparam int HT = HD + HF + HR + HB;
    localparam int HS = HD + HF;
    localparam int VT = VD + VF + VR + VB;
    localparam int VS = VD + VF;

    typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

    state_t     state, state_nxt;
    logic       hs, hs_d, vs, vs_d;
    logic [2:0] rgb_s, rgb_d;
    logic [9:0] h_cnt, v_cnt;
    logic       bad, bad_nxt;
    logic       h_rise, v_rise, h_ok, v_ok, h_wrap, vis;
    logic       err_inc, ft_nxt;

    // h_cnt/v_cnt describe the sample held in hs_d/rgb_d, so an on-time
    // hsync edge is seen while h_cnt still holds HS-1.
    assign h_rise = hs & ~hs_d;
    assign v_rise = vs & ~vs_d;
    assign h_wrap = (h_cnt == 10'(HT - 1));
    assign h_ok   = (h_cnt == 10'(HS - 1));
    assign v_ok   = (v_cnt == 10'(VS)) || ((v_cnt == 10'(VS - 1)) && h_wrap);
    assign vis    = (state == LOCKED) && (h_cnt < 10'(HD)) && (v_cnt < 10'(VD));
    assign locked = (state == LOCKED);

    // Input sampling pipeline, two stages so edges compare consecutive samples
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs    <= 1'b0;
            hs_d  <= 1'b0;
            vs    <= 1'b0;
            vs_d  <= 1'b0;
            rgb_s <= 3'b000;
            rgb_d <= 3'b000;
        end else if (p_tick) begin
            hs    <= hsync;
            hs_d  <= hs;
            vs    <= vsync;
            vs_d  <= vs;
            rgb_s <= rgb;
            rgb_d <= rgb_s;
        end
    end

    // Free-running counters, reloaded by every sync rising edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (p_tick) begin
            if (h_rise)      h_cnt <= 10'(HS);
            else if (h_wrap) h_cnt <= 10'd0;
            else             h_cnt <= h_cnt + 10'd1;

            if (v_rise)                 v_cnt <= 10'(VS);
            else if (h_wrap && !h_rise) v_cnt <= (v_cnt == 10'(VT - 1)) ? 10'd0 : v_cnt + 10'd1;
        end
    end

    // Lock state register and ALIGN-frame error flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= SEARCH;
            bad   <= 1'b0;
        end else if (p_tick) begin
            state <= state_nxt;
            bad   <= bad_nxt;
        end
    end

    // Next-state: ALIGN must see a whole frame of clean hsyncs and an
    // on-time vsync; same-cycle hsync error also blocks the lock.
    always_comb begin
        state_nxt = state;
        bad_nxt   = bad;
        err_inc   = 1'b0;
        ft_nxt    = 1'b0;
        case (state)
            SEARCH: begin
                if (v_rise) begin
                    state_nxt = ALIGN;
                    bad_nxt   = 1'b0;
                end
            end
            ALIGN: begin
                if (h_rise && !h_ok) bad_nxt = 1'b1;
                if (v_rise) begin
                    if (!bad_nxt && v_ok) begin
                        state_nxt = LOCKED;
                        ft_nxt    = 1'b1;
                    end
                    bad_nxt = 1'b0;
                end
            end
            LOCKED: begin
                if ((h_rise && !h_ok) || (v_rise && !v_ok)) begin
                    state_nxt = SEARCH;
                    err_inc   = 1'b1;
                end else if (v_rise) begin
                    ft_nxt = 1'b1;
                end
            end
            default: state_nxt = SEARCH;
        endcase
    end

    // Registered outputs; frame_tick is a single-clk pulse, the rest hold
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pixel_x    <= 10'd0;
            pixel_y    <= 10'd0;
            video_on   <= 1'b0;
            rgb_cap    <= 3'b000;
            err_cnt    <= 8'd0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= p_tick & ft_nxt;
            if (p_tick) begin
                pixel_x  <= h_cnt;
                pixel_y  <= v_cnt;
                video_on <= vis;
                rgb_cap  <= vis ? rgb_d : 3'b000;
                if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx on a miniature raster (8x6 total, 4x3 visible)
// so that multi-frame scenarios stay short.
module tb_vga_sync_rx;
    localparam int HD = 4, HF = 1, HR = 2, HB = 1;
    localparam int VD = 3, VF = 1, VR = 1, VB = 1;
    localparam int HT = HD + HF + HR + HB;
    localparam int HS = HD + HF;
    localparam int VT = VD + VF + VR + VB;
    localparam int VS = VD + VF;

    logic       clk = 1'b0, reset = 1'b1, p_tick = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic [2:0] rgb = 3'b000;
    logic [9:0] pixel_x, pixel_y;
    logic       video_on, locked, frame_tick;
    logic [2:0] rgb_cap;
    logic [7:0] err_cnt;

    vga_sync_rx #(.HD(HD), .HF(HF), .HR(HR), .HB(HB), .VD(VD), .VF(VF), .VR(VR), .VB(VB)) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on), .rgb_cap(rgb_cap),
        .locked(locked), .frame_tick(frame_tick), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         chk;
        logic [9:0] x;
        logic [9:0] y;
        logic       von;
        logic [2:0] c;
    } exp_t;

    exp_t q[$];
    int   checks = 0, errors = 0;
    bit   fast = 1'b0;
    int   pcnt = 0, last_ft = -1, ft_gap = 0, ft_cnt = 0;

    // One pixel of stream; expected output for it is queued and compared
    // two p_ticks later when the DUT presents it.
    task automatic tick(input logic h, input logic v, input logic [2:0] c, input exp_t e);
        logic [32:0] snap;
        exp_t o;
        hsync = h; vsync = v; rgb = c; p_tick = 1'b1;
        q.push_back(e);
        @(negedge clk);
        pcnt++;
        if (frame_tick) begin
            if (last_ft >= 0) ft_gap = pcnt - last_ft;
            last_ft = pcnt;
            ft_cnt++;
        end
        if (q.size() >= 3) begin
            o = q.pop_front();
            if (o.chk) begin
                checks++;
                if ({pixel_x, pixel_y, video_on, rgb_cap} !== {o.x, o.y, o.von, o.c}) begin
                    errors++;
                    $display("FAIL pixel: got x=%0d y=%0d von=%b rgb=%b, want x=%0d y=%0d von=%b rgb=%b",
                             pixel_x, pixel_y, video_on, rgb_cap, o.x, o.y, o.von, o.c);
                end
            end
        end
        if (!fast) begin
            snap = {pixel_x, pixel_y, video_on, rgb_cap, locked, err_cnt};
            p_tick = 1'b0;
            @(negedge clk);
            checks++;
            if ({frame_tick, pixel_x, pixel_y, video_on, rgb_cap, locked, err_cnt} !== {1'b0, snap}) begin
                errors++;
                $display("FAIL hold: got ft=%b outs=%h, want ft=0 outs=%h", frame_tick,
                         {pixel_x, pixel_y, video_on, rgb_cap, locked, err_cnt}, snap);
            end
        end
    endtask

    // Drive one frame of nl lines; el selects a line whose hsync rises one pixel late
    task automatic run_frame(input int nl, input int el, input bit pat, input logic [2:0] cc,
                             input bit chk, input int stop_at,
                             output bit lk_pre, output bit lk_post, output int fts);
        int f0, idx;
        exp_t e;
        logic h, v;
        logic [2:0] c;
        f0 = ft_cnt; idx = 0; lk_pre = 1'b0; lk_post = 1'b0; fts = 0;
        for (int y = 0; y < nl; y++) begin
            for (int x = 0; x < HT; x++) begin
                if (idx == stop_at) return;
                if (y == VS && x == 0) lk_pre = locked;
                h = (x >= HS + ((y == el) ? 1 : 0)) && (x < HS + HR);
                v = (y >= VS) && (y < VS + VR);
                c = pat ? 3'(x + y) : cc;
                e.chk = chk; e.x = 10'(x); e.y = 10'(y);
                e.von = (x < HD) && (y < VD);
                e.c = e.von ? c : 3'b000;
                tick(h, v, c, e);
                idx++;
            end
        end
        lk_post = locked; fts = ft_cnt - f0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0; p_tick = 1'b0; hsync = 1'b0; vsync = 1'b0;
        repeat (2) @(negedge clk);
        q.delete(); last_ft = -1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({pixel_x, pixel_y, video_on, rgb_cap, locked, frame_tick, err_cnt} !== 34'd0) begin
            errors++;
            $display("FAIL reset_state: got %h want 0", {pixel_x, pixel_y, video_on, rgb_cap, locked, frame_tick, err_cnt});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_clean();
        bit a, b; int f;
        run_frame(VT, -1, 1'b1, 3'b000, 1'b0, -1, a, b, f);
        checks++; if (b !== 1'b0 || f != 0) begin errors++; $display("FAIL clean_f0: got lk=%b ft=%0d want lk=0 ft=0", b, f); end
        run_frame(VT, -1, 1'b1, 3'b000, 1'b0, -1, a, b, f);
        checks++; if (a !== 1'b0 || b !== 1'b1 || f != 1) begin errors++; $display("FAIL clean_f1: got pre=%b lk=%b ft=%0d want 0 1 1", a, b, f); end
        run_frame(VT, -1, 1'b1, 3'b000, 1'b1, -1, a, b, f);
        checks++; if (a !== 1'b1 || b !== 1'b1 || f != 1) begin errors++; $display("FAIL clean_f2: got pre=%b lk=%b ft=%0d want 1 1 1", a, b, f); end
        checks++; if (ft_gap != HT * VT) begin errors++; $display("FAIL ft_period: got %0d want %0d", ft_gap, HT * VT); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL clean_err: got %0d want 0", err_cnt); end
    endtask

    task automatic test_hsync_err();
        bit a, b; int f;
        run_frame(VT, VS - 2, 1'b1, 3'b000, 1'b0, -1, a, b, f);
        checks++; if (a !== 1'b0 || err_cnt !== 8'd1) begin errors++; $display("FAIL herr_hit: got lk=%b err=%0d want 0 1", a, err_cnt); end
        checks++; if (b !== 1'b0 || f != 0) begin errors++; $display("FAIL herr_frame: got lk=%b ft=%0d want 0 0", b, f); end
        run_frame(VT, -1, 1'b1, 3'b000, 1'b0, -1, a, b, f);
        checks++; if (b !== 1'b1 || f != 1 || err_cnt !== 8'd1) begin errors++; $display("FAIL herr_relock: got lk=%b ft=%0d err=%0d want 1 1 1", b, f, err_cnt); end
    endtask

    task automatic test_pixels();
        bit a, b; int f;
        run_frame(VT, -1, 1'b0, 3'b101, 1'b1, -1, a, b, f);
        run_frame(VT, -1, 1'b0, 3'b101, 1'b1, -1, a, b, f);
        checks++; if (b !== 1'b1) begin errors++; $display("FAIL pix_lock: got %b want 1", b); end
    endtask

    task automatic test_short_frame();
        bit a, b; int f;
        apply_reset();
        run_frame(VT - 1, -1, 1'b1, 3'b000, 1'b0, -1, a, b, f);
        run_frame(VT, -1, 1'b1, 3'b000, 1'b0, -1, a, b, f);
        checks++; if (b !== 1'b0 || f != 0) begin errors++; $display("FAIL short_nolock: got lk=%b ft=%0d want 0 0", b, f); end
        run_frame(VT, -1, 1'b1, 3'b000, 1'b0, -1, a, b, f);
        checks++; if (b !== 1'b1 || f != 1) begin errors++; $display("FAIL short_relock: got lk=%b ft=%0d want 1 1", b, f); end
    endtask

    task automatic test_reset_mid();
        bit a, b; int f;
        run_frame(VT, -1, 1'b1, 3'b000, 1'b0, 2 * HT + 3, a, b, f);
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL mid_prelock: got %b want 1", locked); end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({pixel_x, pixel_y, video_on, rgb_cap, locked, frame_tick, err_cnt} !== 34'd0) begin
            errors++;
            $display("FAIL mid_reset: got %h want 0", {pixel_x, pixel_y, video_on, rgb_cap, locked, frame_tick, err_cnt});
        end
        repeat (2) @(negedge clk);
        q.delete(); last_ft = -1;
        reset = 1'b1;
        run_frame(VT, -1, 1'b1, 3'b000, 1'b0, -1, a, b, f);
        checks++; if (b !== 1'b0) begin errors++; $display("FAIL mid_align: got %b want 0", b); end
        run_frame(VT, -1, 1'b1, 3'b000, 1'b0, -1, a, b, f);
        checks++; if (b !== 1'b1 || err_cnt !== 8'd0) begin errors++; $display("FAIL mid_relock: got lk=%b err=%0d want 1 0", b, err_cnt); end
    endtask

    task automatic test_saturate();
        bit a, b; int f, want;
        fast = 1'b1;
        for (int i = 0; i < 300; i++) begin
            run_frame(VT, VS - 2, 1'b1, 3'b000, 1'b0, -1, a, b, f);
            want = (i + 1 > 255) ? 255 : i + 1;
            checks++; if (err_cnt !== 8'(want)) begin errors++; $display("FAIL sat_err[%0d]: got %0d want %0d", i, err_cnt, want); end
            run_frame(VT, -1, 1'b1, 3'b000, 1'b0, -1, a, b, f);
            checks++; if (b !== 1'b1) begin errors++; $display("FAIL sat_relock[%0d]: got %b want 1", i, b); end
        end
        fast = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_clean();
        test_hsync_err();
        test_pixels();
        test_short_frame();
        test_reset_mid();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
